// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction fields and streams the words through a 4-deep FIFO to memory.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [2:0]  count_o,
  output logic        err_o,
  output logic        wrap_o
);
  logic [31:0] fifo_q [4];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  count_q, count_d;
  logic [7:0]  addr_q, addr_d;
  logic        err_q, wrap_q;
  logic [5:0]  op;
  logic [31:0] word;
  logic        legal, xfer, push, pop;
  always_comb begin
    op = kind_i == 4'd2 ? 6'd4 : kind_i == 4'd3 ? 6'd5 : kind_i == 4'd4 ? 6'd8 :
         kind_i == 4'd6 ? 6'd13 : kind_i == 4'd7 ? 6'd35 : 6'd43;
    word = kind_i == 4'd0 ? {6'd0, rs_i, rt_i, rd_i, 5'd0, funct_i} :
           kind_i == 4'd1 ? {6'd2, target_i} :
           kind_i == 4'd5 ? {6'd15, 5'd0, rt_i, imm_i} : {op, rs_i, rt_i, imm_i};
    legal = kind_i <= 4'd8;
    xfer = in_valid_i && in_ready_o;
    push = xfer && legal;
    pop = mem_we_o && mem_ready_i;
    count_d = count_q + {2'd0, push} - {2'd0, pop};
    addr_d = pop ? addr_q + 8'd1 : addr_q;
  end
  assign in_ready_o = count_q != 3'd4;
  assign mem_we_o   = count_q != 3'd0;
  assign mem_data_o = mem_we_o ? fifo_q[rptr_q] : 32'd0;
  assign mem_addr_o = {22'd0, addr_q, 2'b00};
  assign count_o    = count_q;
  assign err_o      = err_q;
  assign wrap_o     = wrap_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      addr_q  <= 8'd0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (push) fifo_q[wptr_q] <= word;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop) rptr_q <= rptr_q + 2'd1;
      if (pop && addr_q == 8'hFF) wrap_q <= 1'b1;
      count_q <= count_d;
      addr_q  <= addr_d;
      err_q   <= xfer && !legal;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written backpressure, illegal-kind, wrap and reset sequences.
module tb_instr_encoder;
  logic        clk = 0, rst = 1, in_valid = 0, mem_ready = 0;
  logic [3:0]  kind = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic [5:0]  funct = 0;
  logic [15:0] imm = 0;
  logic [25:0] target = 0;
  logic        in_ready, mem_we, err, wrap;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  count;
  int pass_n = 0, total_n = 0;
  logic [31:0] exp_addr;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
    .target_i(target), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .count_o(count),
    .err_o(err), .wrap_o(wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_n++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    in_valid = 0;
    tick();
    rst = 0;
  endtask

  task automatic set_addi(input logic [15:0] v);
    kind = 4'd4; rs = 5'd0; rt = 5'd8; imm = v;
  endtask

  initial begin
    vt[0] = '{4'd4, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h20080005};
    vt[1] = '{4'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 26'h0,       32'h00221820};
    vt[2] = '{4'd1, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010};
    vt[3] = '{4'd7, 5'd29, 5'd9,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA90004};
    vt[4] = '{4'd2, 5'd1,  5'd2,  5'd7,  6'h3F, 16'hFFFF, 26'h0,       32'h1022FFFF};
    vt[5] = '{4'd3, 5'd3,  5'd4,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h14640010};
    vt[6] = '{4'd5, 5'd31, 5'd5,  5'd9,  6'h11, 16'h1234, 26'h3FFFFFF, 32'h3C051234};
    vt[7] = '{4'd6, 5'd2,  5'd3,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h344300FF};
    vt[8] = '{4'd8, 5'd29, 5'd31, 5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008};
    vt[9] = '{4'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h03FFF83F};

    // reset with a request presented: must not be accepted
    rst = 1; in_valid = 1; set_addi(16'h0001); mem_ready = 0;
    tick(); tick();
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_wrap", {31'd0, wrap}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    in_valid = 0; rst = 0;
    tick();
    chk("rst_no_accept", {29'd0, count}, 0);

    mem_ready = 1;
    exp_addr = 0;
    for (int i = 0; i < 10; i++) begin
      kind = vt[i].kind; rs = vt[i].rs; rt = vt[i].rt; rd = vt[i].rd;
      funct = vt[i].funct; imm = vt[i].imm; target = vt[i].target;
      in_valid = 1;
      tick();
      in_valid = 0;
      chk($sformatf("vec%0d_we", i), {31'd0, mem_we}, 1);
      chk($sformatf("vec%0d_data", i), mem_data, vt[i].exp);
      chk($sformatf("vec%0d_addr", i), mem_addr, exp_addr);
      tick();
      exp_addr += 4;
      chk($sformatf("vec%0d_addr_next", i), mem_addr, exp_addr);
      chk($sformatf("vec%0d_empty", i), {31'd0, mem_we}, 0);
    end

    // backpressure: five back-to-back requests, memory stalled
    do_reset();
    mem_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      set_addi(16'(i));
      tick();
    end
    set_addi(16'd4);
    chk("bp_count4", {29'd0, count}, 4);
    chk("bp_not_ready", {31'd0, in_ready}, 0);
    tick();
    chk("bp_held_count", {29'd0, count}, 4);
    chk("bp_held_data", mem_data, 32'h20080000);
    chk("bp_held_addr", mem_addr, 0);
    mem_ready = 1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp%0d_we", j), {31'd0, mem_we}, 1);
      chk($sformatf("bp%0d_data", j), mem_data, 32'h20080000 | j);
      chk($sformatf("bp%0d_addr", j), mem_addr, 4 * j);
      tick();
      if (j == 1) in_valid = 0;
    end
    chk("bp_drained", {29'd0, count}, 0);

    // illegal kind with empty FIFO
    mem_ready = 0;
    kind = 4'd15; in_valid = 1;
    tick();
    in_valid = 0;
    chk("ill_err", {31'd0, err}, 1);
    chk("ill_count", {29'd0, count}, 0);
    chk("ill_no_write", {31'd0, mem_we}, 0);
    tick();
    chk("ill_err_pulse", {31'd0, err}, 0);

    // illegal kind coinciding with a pop
    set_addi(16'h00AA); in_valid = 1;
    tick();
    kind = 4'd9; mem_ready = 1;
    chk("ill_pop_data", mem_data, 32'h200800AA);
    tick();
    in_valid = 0;
    chk("ill_pop_err", {31'd0, err}, 1);
    chk("ill_pop_count", {29'd0, count}, 0);
    chk("ill_pop_addr", mem_addr, 32'h18);

    // address wrap after 256 words
    do_reset();
    mem_ready = 1;
    in_valid = 1;
    for (int k = 0; k < 257; k++) begin
      set_addi(16'(k));
      tick();
      if (k == 255) begin
        chk("wrap_w256_addr", mem_addr, 32'h3FC);
        chk("wrap_w256_data", mem_data, 32'h200800FF);
        chk("wrap_before", {31'd0, wrap}, 0);
      end
      if (k == 256) begin
        chk("wrap_w257_addr", mem_addr, 32'h000);
        chk("wrap_w257_data", mem_data, 32'h20080100);
        chk("wrap_set", {31'd0, wrap}, 1);
      end
    end
    in_valid = 0;
    tick();
    chk("wrap_sticky", {31'd0, wrap}, 1);
    chk("wrap_addr_after", mem_addr, 32'h004);

    // reset mid-burst with three pending words
    mem_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_addi(16'(i));
      tick();
    end
    in_valid = 0;
    chk("mid_count3", {29'd0, count}, 3);
    rst = 1; mem_ready = 1; in_valid = 1;
    tick();
    rst = 0; in_valid = 0; mem_ready = 1;
    chk("mid_count", {29'd0, count}, 0);
    chk("mid_we", {31'd0, mem_we}, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wrap", {31'd0, wrap}, 0);
    tick();
    chk("mid_no_write", {31'd0, mem_we}, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock, clk_i; reset, rst_i, SHALL be synchronous and active-high.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 in_valid_i  input  1  request fields valid this cycle.
REQ-005 in_ready_o  output  1  block can accept a request this cycle.
REQ-006 kind_i  input  4  instruction kind: 0 R-type, 1 J, 2 BEQ, 3 BNE, 4 ADDI, 5 LUI, 6 ORI, 7 LW, 8 SW; 9-15 illegal.
REQ-007 rs_i, rt_i, rd_i  input  5 each  register fields.
REQ-008 funct_i  input  6  R-type function field.
REQ-009 imm_i  input  16  I-type immediate.
REQ-010 target_i  input  26  J-type target field.
REQ-011 mem_ready_i  input  1  instruction memory accepts the write this cycle.
REQ-012 mem_we_o  output  1  write strobe to instruction memory.
REQ-013 mem_addr_o  output  32  byte address of the current write.
REQ-014 mem_data_o  output  32  encoded instruction word.
REQ-015 count_o  output  3  FIFO occupancy, 0-4.
REQ-016 err_o  output  1  one-cycle pulse: illegal kind consumed.
REQ-017 wrap_o  output  1  sticky flag: address counter has wrapped.

Function
REQ-018 Encoding SHALL be combinational at push time. R-type: {6'd0, rs, rt, rd, 5'd0, funct}. J: {6'd2, target}. BEQ/BNE/ADDI/ORI/LW/SW: {op, rs, rt, imm}, with op = 4, 5, 8, 13, 35, 43. LUI: {6'd15, 5'd0, rt, imm}, rs_i ignored.
REQ-019 Fields that an instruction format does not use SHALL be ignored.
REQ-020 The block SHALL buffer encoded words in a 4-entry FIFO with pointer wrap modulo 4.
REQ-021 in_ready_o SHALL equal (count_o != 4) and SHALL NOT depend on mem_ready_i; a full FIFO does not admit a same-cycle push.
REQ-022 A transfer occurs on a rising edge with in_valid_i && in_ready_o. A legal kind pushes one word; an illegal kind pushes nothing and err_o is 1 in the following cycle only.
REQ-023 mem_we_o SHALL equal (count_o != 0); mem_data_o SHALL be the FIFO head; mem_addr_o SHALL be the address counter.
REQ-024 mem_data_o and mem_addr_o SHALL be held stable while mem_we_o=1 and mem_ready_i=0.
REQ-025 A pop occurs on a rising edge with mem_we_o && mem_ready_i; the address counter then advances by 4.
REQ-026 Latency: a word pushed at edge N SHALL appear on mem_we_o/mem_data_o in the cycle after edge N when the FIFO was empty; there is no combinational bypass.
REQ-027 A simultaneous push and pop SHALL leave count_o unchanged while both pointers advance.
REQ-028 The address counter SHALL span 0x000-0x3FC (256 words). A pop at 0x3FC SHALL set the counter to 0x000 and set wrap_o=1.
REQ-029 mem_addr_o[31:10] and mem_addr_o[1:0] SHALL always be 0.
REQ-030 An illegal-kind transfer coinciding with a pop SHALL affect only the pop.

Reset
REQ-031 While rst_i=1 at an edge, the block SHALL discard FIFO contents and set count_o=0, mem_we_o=0, mem_data_o=0, mem_addr_o=0, err_o=0, wrap_o=0, in_ready_o=1.
REQ-032 Reset SHALL take priority over a simultaneous push or pop; reset mid-burst SHALL drop all pending words with no further writes.
REQ-033 Requests presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-034 ADDI, kind=4, rs=0, rt=8, imm=0x0005, mem_ready_i=1 -> next cycle mem_we_o=1, mem_addr_o=0x000, mem_data_o=0x20080005; following cycle addr=0x004.
REQ-035 Two encodings, each checked on mem_data_o:
- R-type, kind=0, rs=1, rt=2, rd=3, funct=0x20 -> 0x00221820.
- J, kind=1, target=0x0000010 -> 0x08000010.
REQ-036 LW, kind=7, rs=29, rt=9, imm=0x0004 -> mem_data_o=0x8FA90004.
REQ-037 Backpressure and illegal kind:
- mem_ready_i=0, five back-to-back valid requests -> four accepted, count_o=4, in_ready_o=0 while the fifth is held.
- Raise mem_ready_i -> writes at 0x000, 0x004, 0x008, 0x00C on consecutive cycles, then the fifth word at 0x010.
- kind=15 -> err_o=1 for exactly one cycle, count_o unchanged, no write.
REQ-038 Wrap and reset:
- 257 legal requests with mem_ready_i=1 -> word 256 written at 0x3FC, word 257 at 0x000, wrap_o=1 thereafter.
- rst_i with count_o=3 -> next cycle count_o=0, mem_we_o=0, mem_addr_o=0, wrap_o=0.
